wrr_frame_arbiter: RTL

Frame-aware weighted round-robin arbiter that shares one downstream stream datapath (e.g. an AXI-stream mux) between PORTS requesters. Each grant turn allows a port up to `weight[i]` frames before rotation. Grants change only on frame boundaries, which the datapath reports with `frame_done`. An optional watchdog forces rotation off a stalled port.

---
 rtl/wrr_arb_pkg.sv | 12 +
 rtl/wrr_rr_select.sv | 45 ++++
 rtl/wrr_frame_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/wrr_arb_pkg.sv
// Shared types for the frame-aware weighted round-robin arbiter.
// State encoding and the default watchdog limit.
package wrr_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/wrr_rr_select.sv
// Combinational round-robin pick: lowest eligible index strictly above pointer, wrapping.
// Zero latency; the pointer's own port is reachable only as the last (wrapped) candidate.
module wrr_rr_select #(
  parameter int PORTS = 4
) (
  input  logic [PORTS-1:0]         eligible,
  input  logic [$clog2(PORTS)-1:0] pointer,
  output logic                     valid,
  output logic [PORTS-1:0]         onehot,
  output logic [$clog2(PORTS)-1:0] encoded
);

  localparam int IDX_W = $clog2(PORTS);

  logic [2*PORTS-1:0] doubled;
  logic [2*PORTS-1:0] mask;
  logic [2*PORTS-1:0] masked;

  // Upper copy of the request vector supplies the wrapped candidates.
  assign doubled = {eligible, eligible};
  assign masked  = doubled & mask;

  always_comb begin
    mask = '0;
    for (int j = 0; j < 2*PORTS; j++) begin
      mask[j] = (j > int'(pointer));
    end
  end

  always_comb begin
    valid   = 1'b0;
    encoded = '0;
    onehot  = '0;
    for (int j = 2*PORTS-1; j >= 0; j--) begin
      if (masked[j]) begin
        valid   = 1'b1;
        encoded = IDX_W'(j % PORTS);
      end
    end
    if (valid) begin
      onehot[encoded] = 1'b1;
    end
  end

endmodule

// File: rtl/wrr_frame_arbiter.sv
// Frame-aware WRR arbiter: grants move only on frame_done (or watchdog expiry with WRR_ARB_WATCHDOG_EN).
// Grant registered one cycle after request/frame_done; rotation between ports has no bubble.
module wrr_frame_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  input  logic                          frame_done,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded,
  output logic                          timeout
);

  localparam int IDX_W = $clog2(PORTS);

  if (PORTS < 2 || TIMEOUT < 2) begin : g_param_check
    $error("wrr_frame_arbiter: PORTS and TIMEOUT must both be at least 2");
  end

  state_e                  state_q, state_d;
  logic [PORTS-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        enc_q, enc_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic [PORTS-1:0]        eligible;
  logic                    sel_valid;
  logic [PORTS-1:0]        sel_onehot;
  logic [IDX_W-1:0]        sel_encoded;
  logic [WEIGHT_WIDTH-1:0] sel_weight;
  logic                    turn_end;
  logic                    turn_load;
  logic                    wd_expire;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < PORTS; i++) begin
      eligible[i] = request[i] && (weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
    end
  end

  wrr_rr_select #(
    .PORTS (PORTS)
  ) u_select (
    .eligible (eligible),
    .pointer  (ptr_q),
    .valid    (sel_valid),
    .onehot   (sel_onehot),
    .encoded  (sel_encoded)
  );

  // Weight is only ever sampled here, at the start of a turn.
  assign sel_weight = weight[sel_encoded*WEIGHT_WIDTH +: WEIGHT_WIDTH];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    enc_d     = enc_q;
    ptr_d     = ptr_q;
    credit_d  = credit_q;
    turn_end  = 1'b0;
    turn_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          turn_load = 1'b1;
        end
      end
      ST_GRANT: begin
        if (frame_done) begin
          if (credit_q > WEIGHT_WIDTH'(1) && eligible[enc_q]) begin
            credit_d = credit_q - WEIGHT_WIDTH'(1);
          end else begin
            turn_end = 1'b1;
          end
        end else if (wd_expire) begin
          turn_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (turn_end) begin
      if (sel_valid) begin
        turn_load = 1'b1;
      end else begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        enc_d    = '0;
        credit_d = '0;
      end
    end

    // A sole-eligible current port lands here too, reloading credit with grant unchanged.
    if (turn_load) begin
      state_d  = ST_GRANT;
      grant_d  = sel_onehot;
      enc_d    = sel_encoded;
      ptr_d    = sel_encoded;
      credit_d = sel_weight;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      enc_q    <= '0;
      ptr_q    <= IDX_W'(PORTS-1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      enc_q    <= enc_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

`ifdef WRR_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  assign wd_expire = (state_q == ST_GRANT) && (wd_q == WD_W'(TIMEOUT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire && !frame_done;
      if (turn_load || frame_done || state_q != ST_GRANT) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + WD_W'(1);
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign grant         = grant_q;
  assign grant_valid   = |grant_q;
  assign grant_encoded = enc_q;

endmodule
